mem_rd_arb: RTL and testbench
=============================

MEM_RD_ARB -- requirements
Module: mem_rd_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive denied fetch cycles before fetch priority overrides data priority.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 f_req  in  1  fetch read request; f_addr held stable until f_gnt.
REQ-005 f_addr  in  [15:1]  fetch word address.
REQ-006 f_cancel  in  1  pipeline flush; masks the fetch response due this cycle.
REQ-007 f_gnt  out  1  fetch granted this cycle (combinational).
REQ-008 f_rvalid  out  1  fetch data valid on f_rdata.
REQ-009 f_rdata  out  [15:0]  fetch read data (mem_rdata passthrough).
REQ-010 d_req  in  1  data load request; d_addr and d_pair held stable until d_gnt.
REQ-011 d_pair  in  1  request reads d_addr then d_addr+1 (pair load).
REQ-012 d_addr  in  [15:1]  data word address.
REQ-013 d_gnt  out  1  data granted this cycle (combinational).
REQ-014 d_rvalid  out  1  data beat valid on d_rdata.
REQ-015 d_rbeat  out  1  0 = first word, 1 = second word of a pair.
REQ-016 d_rdata  out  [15:0]  data read data (mem_rdata passthrough).
REQ-017 d_busy  out  1  high while a pair's second beat is being issued.
REQ-018 mem_raddr  out  [15:1]  address to the shared memory read port.
REQ-019 mem_rdata  in  [15:0]  memory read data, valid exactly 1 cycle after mem_raddr is presented.

Function
REQ-020 FSM states: ARB (normal arbitration) and PAIR2 (issue second pair beat).
REQ-021 In ARB, d_req SHALL win over f_req unless starve_cnt == STARVE_MAX, in which case f_req wins.
REQ-022 At most one of f_gnt and d_gnt SHALL be high in any cycle; neither is high in PAIR2.
REQ-023 mem_raddr SHALL equal d_addr on d_gnt, pair_addr+1 in PAIR2, and f_addr otherwise.
REQ-024 pair_addr+1 SHALL wrap from 15'h7FFF to 15'h0000.
REQ-025 d_gnt with d_pair=1 SHALL latch d_addr into pair_addr and move ARB->PAIR2; PAIR2 SHALL return to ARB after exactly one cycle.
REQ-026 d_busy SHALL be high exactly when the state is PAIR2.
REQ-027 Read latency: each grant at cycle t SHALL produce the corresponding rvalid at t+1; a pair granted at t SHALL give beat 0 at t+1 and beat 1 at t+2.
REQ-028 f_rvalid SHALL equal f_inflight & ~f_cancel, where f_inflight is f_gnt registered.
REQ-029 A fetch granted in the same cycle as f_cancel SHALL NOT be cancelled.
REQ-030 starve_cnt SHALL increment by 1 when f_req & ~f_gnt, saturate at STARVE_MAX, and clear on f_gnt or ~f_req.
REQ-031 A d_req arriving during PAIR2 SHALL wait, then arbitrate normally in the next ARB cycle.
REQ-032 Request inputs SHALL be ignored while rst is high.

Reset
REQ-033 While rst is high, state SHALL become ARB, starve_cnt 0, and f_inflight, d_inflight and d_rbeat 0.
REQ-034 The cycle after rst, f_rvalid, d_rvalid, d_busy and d_rbeat SHALL be 0; a reset during PAIR2 SHALL abandon the second beat.

Structure
REQ-035 The package mem_arb_pkg SHALL hold the state encoding, the address/data width constants, and the default value of STARVE_MAX.
REQ-036 The saturating starvation counter SHALL be one sub-module, arb_starve_ctr; all other logic SHALL be inline.

Verification
REQ-037 Scenario 1 (single requests):
- Stimulus: f_req=1, f_addr=15'h0010 with mem returning 16'hABCD.
- Required: f_gnt at t, mem_raddr=15'h0010 at t, f_rvalid=1 and f_rdata=16'hABCD at t+1.
REQ-038 Scenario 2 (pair load with wrap):
- Stimulus: d_req=1, d_pair=1, d_addr=15'h7FFF.
- Required: mem_raddr=7FFF then 0000; d_rvalid at t+1 with rbeat=0 and at t+2 with rbeat=1; d_busy=1 at t+1 only.
REQ-039 Scenario 3 (starvation override):
- Stimulus: f_req and d_req both held high continuously, STARVE_MAX=4.
- Required: d_gnt for 4 cycles, then f_gnt on cycle 5, then starve_cnt returns to 0.
REQ-040 Scenario 4 (flush mask):
- Stimulus: f_gnt at t, f_cancel=1 at t+1 with a new f_req.
- Required: f_rvalid=0 at t+1; the new fetch is granted at t+1 and its f_rvalid=1 at t+2.
REQ-041 Scenario 5 (reset mid-pair):
- Stimulus: rst asserted in the PAIR2 cycle.
- Required: in the next cycle, d_rvalid=0, d_busy=0, the state is ARB, and a pending f_req is granted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory read arbiter: arbiter state encoding,
// address/data widths and the default starvation threshold.
package mem_arb_pkg;

  localparam int unsigned AddrW            = 15;  // word address, bits [15:1]
  localparam int unsigned DataW            = 16;
  localparam int unsigned StarveMaxDefault = 4;

  typedef enum logic {
    StArb   = 1'b0,  // normal fetch/data arbitration
    StPair2 = 1'b1   // issuing second beat of a pair load
  } arb_state_e;

  // Counter width able to hold 0..max (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter for the fetch port.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   req      - fetch request present this cycle
//   gnt      - fetch granted this cycle
//   sat      - count has reached Max (fetch must win next arbitration)
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned Max = StarveMaxDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  output logic sat
);

  localparam int unsigned CntW = cnt_width(Max);
  localparam logic [CntW-1:0] MaxC = CntW'(Max);
  localparam logic [CntW-1:0] One  = CntW'(1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req || gnt) begin
      cnt_d = '0;
    end else if (cnt_q != MaxC) begin
      cnt_d = cnt_q + One;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == MaxC);

endmodule

// File: rtl/mem_rd_arb.sv
// Arbitrates a fetch port and a data-load port onto one memory read port
// with one-cycle read latency. Data wins by default; a fetch denied for
// STARVE_MAX consecutive cycles wins next. Pair loads issue a second beat
// at d_addr+1 (wrapping) in a dedicated PAIR2 cycle.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   f_req/f_addr/f_cancel         - fetch request, address, response flush
//   f_gnt/f_rvalid/f_rdata        - fetch grant and response
//   d_req/d_pair/d_addr           - data request, pair flag, address
//   d_gnt/d_rvalid/d_rbeat/d_rdata- data grant and response beats
//   d_busy                        - second pair beat being issued
//   mem_raddr/mem_rdata           - shared memory read port
module mem_rd_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = StarveMaxDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_req,
  input  logic [AddrW:1]   f_addr,
  input  logic             f_cancel,
  output logic             f_gnt,
  output logic             f_rvalid,
  output logic [DataW-1:0] f_rdata,
  input  logic             d_req,
  input  logic             d_pair,
  input  logic [AddrW:1]   d_addr,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic             d_rbeat,
  output logic [DataW-1:0] d_rdata,
  output logic             d_busy,
  output logic [AddrW:1]   mem_raddr,
  input  logic [DataW-1:0] mem_rdata
);

  localparam logic [AddrW:1] AddrOne = AddrW'(1);

  arb_state_e     state_q, state_d;
  logic [AddrW:1] pair_addr_q;
  logic           f_inflight_q, d_inflight_q, d_rbeat_q;
  logic           starve_sat;
  logic           in_arb, in_pair2;

  assign in_pair2 = (state_q == StPair2);
  // Requests are ignored during reset.
  assign in_arb   = !rst && (state_q == StArb);

  arb_starve_ctr #(
    .Max (STARVE_MAX)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .req (f_req && !rst),
    .gnt (f_gnt),
    .sat (starve_sat)
  );

  always_comb begin
    f_gnt   = 1'b0;
    d_gnt   = 1'b0;
    state_d = StArb;  // PAIR2 always lasts exactly one cycle
    if (in_arb) begin
      if (d_req && !(f_req && starve_sat)) begin
        d_gnt = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end
      if (d_gnt && d_pair) begin
        state_d = StPair2;
      end
    end
  end

  always_comb begin
    mem_raddr = f_addr;
    if (d_gnt) begin
      mem_raddr = d_addr;
    end else if (in_pair2) begin
      mem_raddr = pair_addr_q + AddrOne;  // wraps 7FFF -> 0000
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StArb;
      f_inflight_q <= 1'b0;
      d_inflight_q <= 1'b0;
      d_rbeat_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      f_inflight_q <= f_gnt;
      d_inflight_q <= d_gnt || in_pair2;
      d_rbeat_q    <= in_pair2;
    end
  end

  always_ff @(posedge clk) begin
    if (d_gnt && d_pair) begin
      pair_addr_q <= d_addr;
    end
  end

  assign f_rvalid = f_inflight_q && !f_cancel;
  assign f_rdata  = mem_rdata;
  assign d_rvalid = d_inflight_q;
  assign d_rbeat  = d_rbeat_q;
  assign d_rdata  = mem_rdata;
  assign d_busy   = in_pair2;

endmodule

// File: tb/tb_mem_rd_arb.sv
// Bench for mem_rd_arb: a directed table of cycles with literal expected
// outputs, then randomized traffic, all checked against a cycle-level
// reference model of the arbitration rules.
module tb_mem_rd_arb;

  localparam int unsigned SMax = 4;

  logic        clk;
  logic        rst;
  logic        f_req, f_cancel, d_req, d_pair;
  logic [15:1] f_addr, d_addr, mem_raddr;
  logic        f_gnt, f_rvalid, d_gnt, d_rvalid, d_rbeat, d_busy;
  logic [15:0] f_rdata, d_rdata, mem_rdata;

  mem_rd_arb #(
    .STARVE_MAX (SMax)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_cancel  (f_cancel),
    .f_gnt     (f_gnt),
    .f_rvalid  (f_rvalid),
    .f_rdata   (f_rdata),
    .d_req     (d_req),
    .d_pair    (d_pair),
    .d_addr    (d_addr),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rbeat   (d_rbeat),
    .d_rdata   (d_rdata),
    .d_busy    (d_busy),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents as a pure function of address; 0010 holds ABCD.
  function automatic logic [15:0] memfn(input logic [15:1] a);
    if (a == 15'h0010) return 16'hABCD;
    return {a, 1'b0} ^ 16'h5A3C;
  endfunction

  always @(posedge clk) mem_rdata <= memfn(mem_raddr);

  typedef struct {
    bit          rst, f_req;
    logic [15:1] f_addr;
    bit          f_cancel, d_req, d_pair;
    logic [15:1] d_addr;
    bit          e_fg, e_dg;
    logic [15:1] e_raddr;
    bit          e_frv, e_drv, e_beat, e_busy;
    int          e_starve;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 0;

  // Reference model state: pending second beat, starvation count and the
  // responses scheduled for the next cycle.
  bit          m_pend;
  logic [15:1] m_pair;
  int          m_starve;
  bit          rf_v, rd_v, rd_b;
  logic [15:1] rf_a, rd_a;
  bit          last_fg, last_dg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t row(input bit r, input bit fr, input logic [15:1] fa, input bit fc,
                               input bit dr, input bit dp, input logic [15:1] da,
                               input bit efg, input bit edg, input logic [15:1] era,
                               input bit efrv, input bit edrv, input bit eb, input bit ebusy,
                               input int est);
    vec_t v;
    v.rst = r; v.f_req = fr; v.f_addr = fa; v.f_cancel = fc;
    v.d_req = dr; v.d_pair = dp; v.d_addr = da;
    v.e_fg = efg; v.e_dg = edg; v.e_raddr = era;
    v.e_frv = efrv; v.e_drv = edrv; v.e_beat = eb; v.e_busy = ebusy; v.e_starve = est;
    return v;
  endfunction

  task automatic step(input vec_t v, input bit tab);
    bit          fg, dg, efrv;
    logic [15:1] ra, nxt;
    @(negedge clk);
    rst = v.rst; f_req = v.f_req; f_addr = v.f_addr; f_cancel = v.f_cancel;
    d_req = v.d_req; d_pair = v.d_pair; d_addr = v.d_addr;
    #1;
    nxt = 15'((32'(m_pair) + 32'd1) % 32'h8000);
    fg = 0; dg = 0;
    if (!v.rst && !m_pend) begin
      if (v.d_req && !(v.f_req && m_starve == SMax)) dg = 1;
      else if (v.f_req) fg = 1;
    end
    ra = dg ? v.d_addr : (m_pend ? nxt : v.f_addr);
    efrv = rf_v && !v.f_cancel;
    if (chk_en) begin
      chk("model_f_gnt", f_gnt, fg);
      chk("model_d_gnt", d_gnt, dg);
      chk("model_mem_raddr", mem_raddr, ra);
      chk("model_d_busy", d_busy, m_pend);
      chk("model_f_rvalid", f_rvalid, efrv);
      chk("model_d_rvalid", d_rvalid, rd_v);
      chk("model_d_rbeat", d_rbeat, rd_v && rd_b);
      if (efrv) chk("model_f_rdata", f_rdata, memfn(rf_a));
      if (rd_v) chk("model_d_rdata", d_rdata, memfn(rd_a));
    end
    if (tab) begin
      chk("tab_f_gnt", f_gnt, v.e_fg);
      chk("tab_d_gnt", d_gnt, v.e_dg);
      chk("tab_mem_raddr", mem_raddr, v.e_raddr);
      chk("tab_f_rvalid", f_rvalid, v.e_frv);
      chk("tab_d_rvalid", d_rvalid, v.e_drv);
      chk("tab_d_rbeat", d_rbeat, v.e_beat);
      chk("tab_d_busy", d_busy, v.e_busy);
      chk("tab_starve_cnt", dut.u_starve.cnt_q, v.e_starve);
    end
    @(posedge clk);
    if (v.rst) begin
      m_pend = 0; m_starve = 0; rf_v = 0; rd_v = 0; rd_b = 0;
    end else begin
      rf_v = fg; rf_a = v.f_addr;
      if (dg) begin
        rd_v = 1; rd_b = 0; rd_a = v.d_addr;
      end else if (m_pend) begin
        rd_v = 1; rd_b = 1; rd_a = nxt;
      end else begin
        rd_v = 0; rd_b = 0;
      end
      if (!v.f_req || fg) m_starve = 0;
      else if (m_starve < SMax) m_starve++;
      m_pend = dg && v.d_pair;
      if (dg) m_pair = v.d_addr;
    end
    last_fg = fg;
    last_dg = dg;
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    rst = 1; f_req = 0; f_addr = '0; f_cancel = 0; d_req = 0; d_pair = 0; d_addr = '0;
    m_pend = 0; m_pair = '0; m_starve = 0; rf_v = 0; rd_v = 0; rd_b = 0;
    rf_a = '0; rd_a = '0; last_fg = 0; last_dg = 0;

    //                 rst fr faddr    fc dr dp daddr    fg dg raddr    frv drv bt bsy st
    // Reset state
    tbl.push_back(row(0, 0, 15'h0000, 0, 0, 0, 15'h0000, 0, 0, 15'h0000, 0, 0, 0, 0, 0));
    // Single fetch
    tbl.push_back(row(0, 1, 15'h0010, 0, 0, 0, 15'h0000, 1, 0, 15'h0010, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 15'h0000, 0, 0, 0, 15'h0000, 0, 0, 15'h0000, 1, 0, 0, 0, 0));
    // Pair load with address wrap
    tbl.push_back(row(0, 0, 15'h0000, 0, 1, 1, 15'h7FFF, 0, 1, 15'h7FFF, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 15'h0000, 0, 0, 0, 15'h0000, 0, 0, 15'h0000, 0, 1, 0, 1, 0));
    tbl.push_back(row(0, 0, 15'h0000, 0, 0, 0, 15'h0000, 0, 0, 15'h0000, 0, 1, 1, 0, 0));
    // Starvation override: four data grants, then fetch, then data again
    tbl.push_back(row(0, 1, 15'h0100, 0, 1, 0, 15'h0200, 0, 1, 15'h0200, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 1, 15'h0100, 0, 1, 0, 15'h0200, 0, 1, 15'h0200, 0, 1, 0, 0, 1));
    tbl.push_back(row(0, 1, 15'h0100, 0, 1, 0, 15'h0200, 0, 1, 15'h0200, 0, 1, 0, 0, 2));
    tbl.push_back(row(0, 1, 15'h0100, 0, 1, 0, 15'h0200, 0, 1, 15'h0200, 0, 1, 0, 0, 3));
    tbl.push_back(row(0, 1, 15'h0100, 0, 1, 0, 15'h0200, 1, 0, 15'h0100, 0, 1, 0, 0, 4));
    tbl.push_back(row(0, 1, 15'h0100, 0, 1, 0, 15'h0200, 0, 1, 15'h0200, 1, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 15'h0000, 0, 0, 0, 15'h0000, 0, 0, 15'h0000, 0, 1, 0, 0, 1));
    // Flush mask: cancel hides the old response, not the new grant
    tbl.push_back(row(0, 1, 15'h0300, 0, 0, 0, 15'h0000, 1, 0, 15'h0300, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 1, 15'h0301, 1, 0, 0, 15'h0000, 1, 0, 15'h0301, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 15'h0000, 0, 0, 0, 15'h0000, 0, 0, 15'h0000, 1, 0, 0, 0, 0));
    // Reset during PAIR2 abandons the second beat; pending fetch then wins
    tbl.push_back(row(0, 1, 15'h0500, 0, 1, 1, 15'h0400, 0, 1, 15'h0400, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 1, 15'h0500, 0, 0, 0, 15'h0000, 0, 0, 15'h0401, 0, 1, 0, 1, 1));
    tbl.push_back(row(0, 1, 15'h0500, 0, 0, 0, 15'h0000, 1, 0, 15'h0500, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 15'h0000, 0, 0, 0, 15'h0000, 0, 0, 15'h0000, 1, 0, 0, 0, 0));

    v = row(1, 0, 15'h0000, 0, 0, 0, 15'h0000, 0, 0, 15'h0000, 0, 0, 0, 0, 0);
    step(v, 0);
    step(v, 0);
    chk_en = 1;
    foreach (tbl[i]) step(tbl[i], 1);

    // Randomized traffic; addresses held until granted.
    v = row(0, 0, 15'h0000, 0, 0, 0, 15'h0000, 0, 0, 15'h0000, 0, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      if (!v.f_req || last_fg) begin
        v.f_req  = ($urandom_range(0, 3) != 0);
        v.f_addr = ($urandom_range(0, 7) == 0) ? 15'h7FFF : 15'($urandom);
      end
      if (!v.d_req || last_dg) begin
        v.d_req  = ($urandom_range(0, 2) != 0);
        v.d_pair = $urandom_range(0, 1) != 0;
        v.d_addr = ($urandom_range(0, 5) == 0) ? 15'h7FFF : 15'($urandom);
      end
      v.f_cancel = ($urandom_range(0, 3) == 0);
      v.rst      = ($urandom_range(0, 39) == 0);
      step(v, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
